// File: rtl/k12a_sequencer.sv
// k12a_sequencer: fetch/exec sequencer with byte counter, memory wait states, skip flag,
// IRQ entry and wake-from-halt for the K12A core.
module k12a_sequencer #(
  parameter int INST_BYTES = 2,
  parameter int WAIT_WIDTH = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WAIT_WIDTH-1:0] mem_wait_states,
  input  logic                  exec_extra,
  input  logic                  exec_halt,
  input  logic                  skip_en,
  input  logic                  skip_cond,
  input  logic                  irq,
  input  logic                  irq_enable,
  input  logic                  wake,
  output logic [2:0]            state,
  output logic [IDX_WIDTH-1:0]  fetch_index,
  output logic                  mem_enable,
  output logic                  byte_store,
  output logic                  pc_advance,
  output logic                  exec_strobe,
  output logic                  exec2_strobe,
  output logic                  vector_load,
  output logic                  irq_ack,
  output logic                  skip,
  output logic                  halted
);
  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] SKIP  = 3'd1;
  localparam logic [2:0] PCINC = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] EXEC2 = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;
  localparam logic [2:0] IRQ   = 3'd6;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [2:0] state_n;
  logic skip_now, wait_done, last_byte, irq_take, done_n;
  logic [2:0] done_state;
  assign skip_now = state == FETCH && fetch_index == '0 && skip;
  assign wait_done = wait_cnt == mem_wait_states;
  assign last_byte = fetch_index == IDX_WIDTH'(INST_BYTES - 1);
  assign irq_take = irq & irq_enable;
  assign done_n = irq_take;
  assign done_state = done_n ? IRQ : FETCH;
  // memory strobes are held low while reset is asserted even though state reads FETCH
  assign mem_enable = !reset && state == FETCH && !skip_now;
  assign byte_store = mem_enable && wait_done;
  assign pc_advance = state == SKIP || state == PCINC;
  assign exec_strobe = state == EXEC;
  assign exec2_strobe = state == EXEC2;
  assign vector_load = state == IRQ;
  assign irq_ack = state == IRQ;
  assign halted = state == HALT;
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH: state_n = skip_now ? SKIP : (byte_store && last_byte) ? PCINC : FETCH;
      PCINC: state_n = EXEC;
      EXEC:  state_n = exec_halt ? HALT : exec_extra ? EXEC2 : done_state;
      EXEC2: state_n = done_state;
      HALT:  state_n = irq_take ? IRQ : wake ? FETCH : HALT;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      fetch_index <= '0;
      wait_cnt <= '0;
      skip <= 1'b0;
    end else begin
      state <= state_n;
      if (mem_enable) begin
        wait_cnt <= wait_done ? '0 : wait_cnt + WAIT_WIDTH'(1);
        if (wait_done) fetch_index <= last_byte ? '0 : fetch_index + IDX_WIDTH'(1);
      end
      skip <= (state == SKIP || state == IRQ) ? 1'b0 : (state == EXEC && skip_en) ? skip_cond : skip;
    end
  end
endmodule

// File: tb/tb_k12a_sequencer.sv
// tb_k12a_sequencer: builds the expected cycle trace of each instruction from its parameters
// and compares every cycle of the sequencer against it.
module tb_k12a_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] mem_wait_states = '0;
  logic exec_extra = 0, exec_halt = 0, skip_en = 0, skip_cond = 0, irq = 0, irq_enable = 0, wake = 0;
  logic [2:0] state;
  logic [1:0] fetch_index;
  logic mem_enable, byte_store, pc_advance, exec_strobe, exec2_strobe, vector_load, irq_ack, skip, halted;
  k12a_sequencer dut (
    .clock(clock), .reset(reset), .mem_wait_states(mem_wait_states), .exec_extra(exec_extra),
    .exec_halt(exec_halt), .skip_en(skip_en), .skip_cond(skip_cond), .irq(irq),
    .irq_enable(irq_enable), .wake(wake), .state(state), .fetch_index(fetch_index),
    .mem_enable(mem_enable), .byte_store(byte_store), .pc_advance(pc_advance),
    .exec_strobe(exec_strobe), .exec2_strobe(exec2_strobe), .vector_load(vector_load),
    .irq_ack(irq_ack), .skip(skip), .halted(halted)
  );
  always #5 clock = ~clock;
  localparam logic [2:0] S_FETCH = 3'd0, S_SKIP = 3'd1, S_PCINC = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_EXEC2 = 3'd4, S_HALT = 3'd5, S_IRQ = 3'd6;
  localparam logic [8:0] ME = 9'h100, BS = 9'h080, PA = 9'h040, ES = 9'h020, E2 = 9'h010;
  localparam logic [8:0] VL = 9'h008, ACK = 9'h004, SK = 9'h002, HL = 9'h001;
  typedef struct {
    logic [2:0] st;
    logic [1:0] idx;
    logic [8:0] o;
    logic iq, ie, wk, dec;
  } cyc_t;
  cyc_t pq[$];
  int checks = 0, passes = 0, fails = 0, ncyc = 0;
  logic m_skip = 1'b0;
  int g_w = 0;
  logic g_ex, g_hlt, g_sen, g_sc, g_iq, g_ie;
  function automatic cyc_t mk(input logic [2:0] st, input int idx, input logic [8:0] o);
    cyc_t c;
    c.st = st;
    c.idx = 2'(idx);
    c.o = o | (m_skip ? SK : 9'h0);
    c.iq = g_iq;
    c.ie = g_ie;
    c.wk = 1'($urandom);
    c.dec = st == S_EXEC;
    return c;
  endfunction
  task automatic plan(input int w, input logic ex, hlt, sen, sc, iq, ie, input int hlen, input logic hirq);
    cyc_t c;
    pq.delete();
    g_w = w; g_ex = ex; g_hlt = hlt; g_sen = sen; g_sc = sc; g_iq = iq; g_ie = ie;
    if (m_skip) begin
      pq.push_back(mk(S_FETCH, 0, 9'h0));
      pq.push_back(mk(S_SKIP, 0, PA));
      m_skip = 1'b0;
    end
    for (int b = 0; b < 2; b++)
      for (int k = 0; k <= w; k++) pq.push_back(mk(S_FETCH, b, (k == w) ? (ME | BS) : ME));
    pq.push_back(mk(S_PCINC, 0, PA));
    pq.push_back(mk(S_EXEC, 0, ES));
    if (sen) m_skip = sc;
    if (hlt) begin
      for (int j = 0; j <= hlen; j++) begin
        c = mk(S_HALT, 0, HL);
        c.iq = (j < hlen) ? 1'b1 : hirq ? 1'b1 : 1'($urandom);
        c.ie = (j == hlen) && hirq;
        c.wk = (j == hlen) ? (hirq ? 1'($urandom) : 1'b1) : 1'b0;
        pq.push_back(c);
      end
      if (hirq) begin
        pq.push_back(mk(S_IRQ, 0, VL | ACK));
        m_skip = 1'b0;
      end
    end else begin
      if (ex) pq.push_back(mk(S_EXEC2, 0, E2));
      if (iq && ie) begin
        pq.push_back(mk(S_IRQ, 0, VL | ACK));
        m_skip = 1'b0;
      end
    end
  endtask
  task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] idx, input logic [8:0] o);
    logic [8:0] got;
    got = {mem_enable, byte_store, pc_advance, exec_strobe, exec2_strobe, vector_load, irq_ack, skip, halted};
    checks++;
    assert (state === st) passes++;
    else begin fails++; $error("FAIL %s state cyc %0d: got %0d want %0d", tag, ncyc, state, st); end
    checks++;
    assert (fetch_index === idx) passes++;
    else begin fails++; $error("FAIL %s fetch_index cyc %0d: got %0d want %0d", tag, ncyc, fetch_index, idx); end
    checks++;
    assert (got === o) passes++;
    else begin fails++; $error("FAIL %s outputs cyc %0d: got %b want %b", tag, ncyc, got, o); end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n && i < pq.size(); i++) begin
      @(negedge clock);
      mem_wait_states = 4'(g_w);
      irq = pq[i].iq;
      irq_enable = pq[i].ie;
      wake = pq[i].wk;
      exec_extra = pq[i].dec ? g_ex : 1'($urandom);
      exec_halt = pq[i].dec ? g_hlt : 1'($urandom);
      skip_en = pq[i].dec ? g_sen : 1'($urandom);
      skip_cond = pq[i].dec ? g_sc : 1'($urandom);
      #1;
      chk("seq", pq[i].st, pq[i].idx, pq[i].o);
      ncyc++;
    end
  endtask
  task automatic mid_reset();
    #1 reset = 1'b1;
    #1 chk("reset_async", S_FETCH, 2'd0, 9'h0);
    m_skip = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask
  initial begin
    #2 chk("reset_init", S_FETCH, 2'd0, 9'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    plan(2, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    plan(0, 0, 0, 1, 1, 0, 0, 0, 0); run(1000);
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    plan(0, 0, 1, 0, 0, 0, 0, 10, 0); run(1000);
    plan(0, 1, 0, 0, 0, 1, 1, 0, 0); run(1000);
    plan(0, 0, 0, 0, 0, 1, 1, 0, 0); run(1000);
    plan(1, 0, 1, 1, 1, 0, 0, 2, 0); run(1000);
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    plan(1, 0, 0, 0, 0, 0, 0, 0, 0); run(4);
    mid_reset();
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    plan(0, 0, 0, 1, 1, 0, 0, 0, 0); run(1000);
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(2);
    mid_reset();
    plan(0, 0, 0, 0, 0, 0, 0, 0, 0); run(1000);
    for (int n = 0; n < 200; n++) begin
      plan($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 4), 1'($urandom));
      run(1000);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
